sdrc_wb_burst_master: RTL

- Wishbone B3 burst master sitting directly upstream of the SDRAM controller's Wishbone slave port; drives wb_stb/cyc/we/addr/dat/sel/cti into the controller.
- Accepts write or read burst commands on a simple valid/ready port. Generates deterministic write data. Checks read-back data against the same pattern.
- Counts mismatches. Used as the traffic source and self-checker for controller bring-up.

---
 rtl/sdrc_wb_burst_master.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/sdrc_wb_burst_master.sv
// Wishbone B3 burst master for SDRAM controller bring-up: writes a seed+beat pattern, reads it back and counts mismatches.
// Optional ack watchdog enabled by defining WB_MASTER_TIMEOUT_EN.
module sdrc_wb_burst_master #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned LW      = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            sdr_init_done,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [LW-1:0]   cmd_len,
  input  logic [DW-1:0]   cmd_seed,
  input  logic            err_clr,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_addr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [2:0]      wb_cti_o,
  input  logic            wb_ack_i,
  input  logic [DW-1:0]   wb_dat_i,
  output logic            busy,
  output logic            done,
  output logic [15:0]     err_cnt
`ifdef WB_MASTER_TIMEOUT_EN
  ,
  output logic            timeout
`endif
);

  localparam int unsigned SW      = DW / 8;
  localparam logic [2:0]  CTI_INC = 3'b010;
  localparam logic [2:0]  CTI_END = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   beat_q, beat_d, len_q, len_d;
  logic [AW-1:0]   base_q, base_d;
  logic [DW-1:0]   seed_q, seed_d;
  logic            we_q, we_d;
  logic            cyc_d, we_o_d, busy_d, done_d;
  logic [AW-1:0]   addr_d;
  logic [DW-1:0]   dat_d;
  logic [SW-1:0]   sel_d;
  logic [2:0]      cti_d;
  logic [15:0]     err_d;
  logic            mismatch_c;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0]   wd_q, wd_d;
  logic            timeout_d;
`else
  logic [31:0]     timeout_unused;
  assign timeout_unused = 32'(TIMEOUT);
`endif

  // Ready is a live view of idle+init so a command is taken on the edge right after init rises.
  assign cmd_ready = wb_rst_i && (state_q == S_IDLE) && sdr_init_done;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    len_d      = len_q;
    base_d     = base_q;
    seed_d     = seed_q;
    we_d       = we_q;
    cyc_d      = 1'b0;
    we_o_d     = 1'b0;
    addr_d     = '0;
    dat_d      = '0;
    sel_d      = '0;
    cti_d      = '0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = err_cnt;
    mismatch_c = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
    wd_d       = wd_q;
    timeout_d  = timeout;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          base_d  = {cmd_addr[AW-1:2], 2'b00};
          len_d   = cmd_len;
          seed_d  = cmd_seed;
          we_d    = cmd_write;
          beat_d  = '0;
          state_d = S_BURST;
`ifdef WB_MASTER_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end
      S_BURST: begin
        if (wb_ack_i) begin
          mismatch_c = !we_q && (wb_dat_i != seed_q + DW'(beat_q));
`ifdef WB_MASTER_TIMEOUT_EN
          wd_d = '0;
`endif
          if (beat_q == len_q) state_d = S_DONE;
          else                 beat_d  = beat_q + LW'(1);
        end
`ifdef WB_MASTER_TIMEOUT_EN
        else if (wd_q == WW'(TIMEOUT - 1)) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + WW'(1);
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Clear wins over the running count, but a same-cycle mismatch still lands.
    if (err_clr)                                 err_d = {15'd0, mismatch_c};
    else if (mismatch_c && err_cnt != 16'hFFFF)  err_d = err_cnt + 16'd1;

    // Bus outputs are registered, so they are built from the next-cycle state.
    if (state_d == S_BURST) begin
      cyc_d  = 1'b1;
      we_o_d = we_d;
      addr_d = base_d + AW'({beat_d, 2'b00});
      dat_d  = seed_d + DW'(beat_d);
      sel_d  = '1;
      cti_d  = (beat_d == len_d) ? CTI_END : CTI_INC;
      busy_d = 1'b1;
    end
    if (state_d == S_DONE) begin
      busy_d = 1'b1;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      len_q     <= '0;
      base_q    <= '0;
      seed_q    <= '0;
      we_q      <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_addr_o <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= '0;
      wb_cti_o  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_cnt   <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
      wd_q      <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      len_q     <= len_d;
      base_q    <= base_d;
      seed_q    <= seed_d;
      we_q      <= we_d;
      wb_cyc_o  <= cyc_d;
      wb_stb_o  <= cyc_d;
      wb_we_o   <= we_o_d;
      wb_addr_o <= addr_d;
      wb_dat_o  <= dat_d;
      wb_sel_o  <= sel_d;
      wb_cti_o  <= cti_d;
      busy      <= busy_d;
      done      <= done_d;
      err_cnt   <= err_d;
`ifdef WB_MASTER_TIMEOUT_EN
      wd_q      <= wd_d;
      timeout   <= timeout_d;
`endif
    end
  end

endmodule
